// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the execute->memory bus layout, select codes and store exception rules.
package mem_stage_pkg;

    localparam int EXE_MEM_W = 190;
    localparam int MEM_WB_W  = 70;

    localparam logic [2:0] WB_SEL_LOAD = 3'b001;
    localparam logic [2:0] WB_SEL_PC4  = 3'b010;

    localparam logic [3:0] CSR_CMD_WRITE = 4'b0001;
    localparam logic [3:0] CSR_CMD_SET   = 4'b0010;
    localparam logic [3:0] CSR_CMD_CLEAR = 4'b0100;

    localparam logic [5:0]  EXC_STORE_MISALIGN = 6'b100110;
    localparam logic [5:0]  EXC_STORE_FAULT    = 6'b100111;
    localparam logic [31:0] STORE_ADDR_LIMIT   = 32'h6000_0000;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } store_state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] store_data;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1;
        logic [31:0] load_data;
        logic [2:0]  mem_size;
    } es_mem_t;

    // Bit 2 of mem_size only carries load sign-extension, so it plays no part here.
    function automatic mem_size_e size_decode(input logic [1:0] sz);
        if (!sz[0])
            return SZ_WORD;
        else if (!sz[1])
            return SZ_HALF;
        else
            return SZ_BYTE;
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store lane alignment: byte strobes, lane-replicated data and misalignment flag.
// Purely combinational; no handshake.
module mem_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mem_size,
    input  logic [31:0] store_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        wstrb    = 4'b1111;
        wdata    = store_data;
        misalign = |addr_lo;
        case (size_decode(mem_size))
            SZ_HALF: begin
                wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                misalign = addr_lo[0];
            end
            SZ_BYTE: begin
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                misalign = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers the execute bus, runs stores over req/ack, issues CSR writes.
// Non-stores pass with no added latency; stores stall until ack and park in DONE under back-pressure.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EXE_MEM_W-1:0] es_mem_bus,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    output logic                 ms_to_ws_valid,
    input  logic                 ws_allowin,
    input  logic [5:0]           exception_code_em,
    input  logic                 exception_flush,
    output logic                 dm_req,
    input  logic                 dm_ack,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wstrb,
    output logic [31:0]          dm_wdata,
    output logic                 csr_we,
    output logic [11:0]          csr_waddr,
    output logic [31:0]          csr_wdata,
    output logic [MEM_WB_W-1:0]  ms_wb_bus,
    output logic [37:0]          ms_id_data_bus,
    output logic [5:0]           exception_code_mw
);

    es_mem_t      bus_r;
    logic [5:0]   exc_em_r;
    logic         ms_valid;
    store_state_e st;

    logic [3:0]   st_wstrb;
    logic [31:0]  st_wdata;
    logic         st_misalign;
    logic [5:0]   exc_mw;
    logic         no_exc;
    logic         store_active;
    logic         ms_ready_go;
    logic         leave;
    logic         csr_hit;
    logic [31:0]  wb_value;
    logic         unused_bits;

    // Flush wins over capture, so an entry arriving in the flush cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
            exc_em_r <= '0;
        end else if (exception_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                bus_r    <= es_mem_bus;
                exc_em_r <= exception_code_em;
            end
        end
    end

    mem_store_align u_align (
        .addr_lo    (bus_r.alu_result[1:0]),
        .mem_size   (bus_r.mem_size[1:0]),
        .store_data (bus_r.store_data),
        .wstrb      (st_wstrb),
        .wdata      (st_wdata),
        .misalign   (st_misalign)
    );

    always_comb begin
        exc_mw = '0;
        if (exc_em_r[5])
            exc_mw = exc_em_r;
        else if (bus_r.mem_we && st_misalign)
            exc_mw = EXC_STORE_MISALIGN;
        else if (bus_r.mem_we && (bus_r.alu_result > STORE_ADDR_LIMIT))
            exc_mw = EXC_STORE_FAULT;
    end

    assign no_exc         = (exc_mw == 6'd0);
    assign store_active   = bus_r.mem_we && no_exc;
    assign dm_req         = ms_valid && store_active && (st != ST_DONE);
    assign ms_ready_go    = !store_active || (dm_req && dm_ack) || (st == ST_DONE);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign leave          = ms_to_ws_valid && ws_allowin;

    // DONE remembers a consumed ack while writeback stalls, preventing a second request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else if (exception_flush || leave) begin
            st <= ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: if (ms_valid && store_active) st <= dm_ack ? ST_DONE : ST_REQ;
                ST_REQ:  if (dm_ack) st <= ST_DONE;
                ST_DONE: st <= ST_DONE;
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign dm_addr  = {bus_r.alu_result[31:2], 2'b00};
    assign dm_wstrb = bus_r.mem_we ? st_wstrb : 4'b0000;
    assign dm_wdata = st_wdata;

    always_comb begin
        csr_hit   = 1'b0;
        csr_wdata = '0;
        case (bus_r.csr_cmd)
            CSR_CMD_WRITE: begin csr_hit = 1'b1; csr_wdata = bus_r.op1; end
            CSR_CMD_SET:   begin csr_hit = 1'b1; csr_wdata = bus_r.alu_result | bus_r.op1; end
            CSR_CMD_CLEAR: begin csr_hit = 1'b1; csr_wdata = bus_r.alu_result & ~bus_r.op1; end
            default: ;
        endcase
    end

    // Tied to the leaving handshake so a stalled CSR instruction writes exactly once.
    assign csr_we    = leave && no_exc && csr_hit;
    assign csr_waddr = bus_r.csr_addr;

    always_comb begin
        case (bus_r.wb_sel)
            WB_SEL_LOAD: wb_value = bus_r.load_data;
            WB_SEL_PC4:  wb_value = bus_r.pc + 32'd4;
            default:     wb_value = bus_r.alu_result;
        endcase
    end

    assign ms_wb_bus         = {wb_value, bus_r.rd, bus_r.rd_wen, bus_r.pc};
    assign ms_id_data_bus    = {wb_value, bus_r.rd_wen & ms_valid, bus_r.rd};
    assign exception_code_mw = exc_mw;

    assign unused_bits = ^{bus_r.mem_re, bus_r.mem_size[2]};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [EXE_MEM_W-1:0] es_mem_bus;
    logic                 es_to_ms_valid;
    logic                 ms_allowin;
    logic                 ms_to_ws_valid;
    logic                 ws_allowin;
    logic [5:0]           exception_code_em;
    logic                 exception_flush;
    logic                 dm_req;
    logic                 dm_ack;
    logic [31:0]          dm_addr;
    logic [3:0]           dm_wstrb;
    logic [31:0]          dm_wdata;
    logic                 csr_we;
    logic [11:0]          csr_waddr;
    logic [31:0]          csr_wdata;
    logic [MEM_WB_W-1:0]  ms_wb_bus;
    logic [37:0]          ms_id_data_bus;
    logic [5:0]           exception_code_mw;

    mem_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .es_mem_bus        (es_mem_bus),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .exception_code_em (exception_code_em),
        .exception_flush   (exception_flush),
        .dm_req            (dm_req),
        .dm_ack            (dm_ack),
        .dm_addr           (dm_addr),
        .dm_wstrb          (dm_wstrb),
        .dm_wdata          (dm_wdata),
        .csr_we            (csr_we),
        .csr_waddr         (csr_waddr),
        .csr_wdata         (csr_wdata),
        .ms_wb_bus         (ms_wb_bus),
        .ms_id_data_bus    (ms_id_data_bus),
        .exception_code_mw (exception_code_mw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wb;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] csr_wdata;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        store;
        logic        csr_ok;
        logic [3:0]  wstrb;
        logic [5:0]  exc;
    } exp_t;

    exp_t res;
    logic res_v;
    logic res_acked;
    int   n_checks;
    int   n_err;
    int   n_req;
    int   n_ack;
    int   n_csr;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected architectural effect of one instruction, derived from the stage's rules.
    function automatic exp_t predict(input es_mem_t b, input logic [5:0] em);
        exp_t        e;
        logic [31:0] a;
        logic        mis;
        logic        fault;
        a = b.alu_result;
        if (b.mem_size[0] == 1'b0) begin
            e.wstrb = 4'hF;
            e.wdata = b.store_data;
            mis     = (a % 4) != 0;
        end else if (b.mem_size[1] == 1'b0) begin
            e.wstrb = 4'(3 << (a & 32'd2));
            e.wdata = {16'b0, b.store_data[15:0]} * 32'h0001_0001;
            mis     = (a % 2) != 0;
        end else begin
            e.wstrb = 4'(1 << (a % 4));
            e.wdata = {24'b0, b.store_data[7:0]} * 32'h0101_0101;
            mis     = 1'b0;
        end
        fault = a > 32'h6000_0000;
        if (em[5])                  e.exc = em;
        else if (b.mem_we && mis)   e.exc = 6'b100110;
        else if (b.mem_we && fault) e.exc = 6'b100111;
        else                        e.exc = 6'd0;
        e.addr = a & 32'hFFFF_FFFC;
        if (b.wb_sel == 3'd1)      e.wb = b.load_data;
        else if (b.wb_sel == 3'd2) e.wb = b.pc + 32'd4;
        else                       e.wb = a;
        e.csr_ok = 1'b1;
        if (b.csr_cmd == 4'd1)      e.csr_wdata = b.op1;
        else if (b.csr_cmd == 4'd2) e.csr_wdata = a | b.op1;
        else if (b.csr_cmd == 4'd4) e.csr_wdata = a & ~b.op1;
        else begin
            e.csr_ok    = 1'b0;
            e.csr_wdata = 32'd0;
        end
        e.csr_ok   = e.csr_ok && (e.exc == 6'd0);
        e.store    = b.mem_we;
        e.rd       = b.rd;
        e.rd_wen   = b.rd_wen;
        e.pc       = b.pc;
        e.csr_addr = b.csr_addr;
        return e;
    endfunction

    function automatic es_mem_t mk(input logic [31:0] alu, input logic we, input logic [2:0] wsel,
                                   input logic [31:0] sd, input logic [3:0] cmd, input logic [31:0] op1,
                                   input logic [31:0] ld, input logic [2:0] size);
        es_mem_t b;
        b            = '0;
        b.alu_result = alu;
        b.rd         = 5'd7;
        b.rd_wen     = 1'b1;
        b.mem_we     = we;
        b.wb_sel     = wsel;
        b.pc         = 32'h0000_4000;
        b.store_data = sd;
        b.csr_cmd    = cmd;
        b.csr_addr   = 12'h300;
        b.op1        = op1;
        b.load_data  = ld;
        b.mem_size   = size;
        return b;
    endfunction

    // One clock cycle: drive at negedge, check settled outputs, advance the model at posedge.
    task automatic step(input logic vld, input es_mem_t b, input logic [5:0] em,
                        input logic ws, input logic ack, input logic fl);
        logic exp_req, exp_ready, exp_out, exp_allow, exp_csr, leave, cap, ackd;
        es_to_ms_valid    = vld;
        es_mem_bus        = b;
        exception_code_em = em;
        ws_allowin        = ws;
        exception_flush   = fl;
        dm_ack            = 1'b0;
        #1;
        dm_ack = ack && dm_req && !fl;
        #1;
        exp_req   = res_v && res.store && (res.exc == 6'd0) && !res_acked;
        exp_ready = !(res.store && (res.exc == 6'd0)) || res_acked || dm_ack;
        exp_out   = res_v && exp_ready;
        exp_allow = !res_v || (exp_ready && ws);
        check("dm_req", dm_req, exp_req);
        if (exp_req) begin
            check("dm_addr", dm_addr, res.addr);
            check("dm_wstrb", dm_wstrb, res.wstrb);
            check("dm_wdata", dm_wdata, res.wdata);
        end
        check("ms_to_ws_valid", ms_to_ws_valid, exp_out);
        check("ms_allowin", ms_allowin, exp_allow);
        if (exp_out) begin
            check("ms_wb_bus", ms_wb_bus, {res.wb, res.rd, res.rd_wen, res.pc});
            check("ms_id_data_bus", ms_id_data_bus, {res.wb, res.rd_wen, res.rd});
            check("exception_code_mw", exception_code_mw, res.exc);
        end
        exp_csr = exp_out && ws && res.csr_ok;
        check("csr_we", csr_we, exp_csr);
        if (exp_csr) begin
            check("csr_waddr", csr_waddr, res.csr_addr);
            check("csr_wdata", csr_wdata, res.csr_wdata);
        end
        if (dm_req) n_req++;
        if (dm_req && dm_ack) n_ack++;
        if (csr_we) n_csr++;
        leave = exp_out && ws;
        cap   = vld && exp_allow && !fl;
        ackd  = exp_req && dm_ack;
        @(posedge clk);
        if (fl) begin
            res_v = 1'b0;
        end else begin
            if (ackd) res_acked = 1'b1;
            if (leave) res_v = 1'b0;
            if (cap) begin
                res       = predict(b, em);
                res_v     = 1'b1;
                res_acked = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ws, input logic ack, input logic fl);
        step(1'b0, '0, 6'd0, ws, ack, fl);
    endtask

    function automatic es_mem_t rand_bus();
        es_mem_t     b;
        logic [3:0]  cmds [6];
        logic [31:0] a;
        cmds = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3};
        case ($urandom % 4)
            0:       a = $urandom & 32'h0000_FFFF;
            1:       a = 32'h6000_0000 + ($urandom % 8) - 32'd4;
            2:       a = $urandom;
            default: a = 32'h0000_1000 + ($urandom % 8);
        endcase
        b            = '0;
        b.alu_result = a;
        b.rd         = 5'($urandom);
        b.rd_wen     = 1'($urandom);
        b.mem_we     = ($urandom % 5) < 2;
        b.mem_re     = 1'($urandom);
        b.wb_sel     = 3'($urandom);
        b.pc         = $urandom;
        b.store_data = $urandom;
        b.csr_cmd    = cmds[$urandom % 6];
        b.csr_addr   = 12'($urandom);
        b.op1        = $urandom;
        b.load_data  = $urandom;
        b.mem_size   = 3'($urandom);
        return b;
    endfunction

    initial begin
        int n0;
        int n1;
        logic ws;
        logic [5:0] em;
        n_checks = 0; n_err = 0; n_req = 0; n_ack = 0; n_csr = 0;
        res = '{default: '0};
        res_v = 1'b0; res_acked = 1'b0;
        rst_n = 1'b0;
        es_mem_bus = '0; es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        exception_code_em = '0; exception_flush = 1'b0; dm_ack = 1'b0;
        @(negedge clk);
        check("rst_allowin", ms_allowin, 1'b1);
        check("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_dm_wstrb", dm_wstrb, 4'd0);
        check("rst_wb_bus", ms_wb_bus, 70'd0);
        check("rst_id_bus", ms_id_data_bus, 38'd0);
        check("rst_exc", exception_code_mw, 6'd0);
        check("rst_csr", {csr_we, csr_waddr, csr_wdata}, 45'd0);
        rst_n = 1'b1;

        // Load word passes straight through
        n0 = n_req;
        step(1'b1, mk(32'h100, 1'b0, 3'b001, 32'd0, 4'd0, 32'd0, 32'hDEAD_BEEF, 3'b010), 6'd0, 1'b1, 1'b0, 1'b0);
        check("lw_valid", ms_to_ws_valid, 1'b1);
        check("lw_value", ms_wb_bus[69:38], 32'hDEAD_BEEF);
        idle(1'b1, 1'b0, 1'b0);
        check("lw_no_req", n_req - n0, 0);

        // Byte store at 0x1003 acked on the third request cycle
        n0 = n_req;
        step(1'b1, mk(32'h1003, 1'b1, 3'b000, 32'h0000_00A5, 4'd0, 32'd0, 32'd0, 3'b011), 6'd0, 1'b1, 1'b0, 1'b0);
        check("sb_addr", dm_addr, 32'h0000_1000);
        check("sb_wstrb", dm_wstrb, 4'b1000);
        check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
        check("sb_stall", ms_allowin, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        check("sb_req_cycles", n_req - n0, 3);

        // Misaligned half store and store access fault
        n0 = n_req;
        step(1'b1, mk(32'h1001, 1'b1, 3'b000, 32'h1234, 4'd1, 32'd5, 32'd0, 3'b001), 6'd0, 1'b1, 1'b0, 1'b0);
        check("sh_exc", exception_code_mw, 6'b100110);
        check("sh_pass", ms_to_ws_valid, 1'b1);
        step(1'b1, mk(32'h6000_0004, 1'b1, 3'b000, 32'h1, 4'd0, 32'd0, 32'd0, 3'b000), 6'd0, 1'b1, 1'b0, 1'b0);
        check("sw_fault_exc", exception_code_mw, 6'b100111);
        idle(1'b1, 1'b1, 1'b0);
        check("exc_no_req", n_req - n0, 0);

        // CSR set with two cycles of writeback back-pressure
        n0 = n_csr;
        step(1'b1, mk(32'h0F, 1'b0, 3'b000, 32'd0, 4'b0010, 32'hF0, 32'd0, 3'b000), 6'd0, 1'b1, 1'b0, 1'b0);
        check("csr_data", csr_wdata, 32'h0000_00FF);
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        check("csr_once", n_csr - n0, 1);

        // Store acked while writeback stalls for four cycles
        n0 = n_ack; n1 = n_req;
        step(1'b1, mk(32'h2000, 1'b1, 3'b000, 32'h55AA, 4'd0, 32'd0, 32'd0, 3'b000), 6'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        check("done_one_ack", n_ack - n0, 1);
        check("done_one_req", n_req - n1, 1);

        // Flush while a request is outstanding, then a clean store
        n0 = n_csr;
        step(1'b1, mk(32'h3000, 1'b1, 3'b000, 32'h77, 4'd1, 32'd9, 32'd0, 3'b000), 6'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b1);
        check("flush_req", dm_req, 1'b0);
        check("flush_valid", ms_to_ws_valid, 1'b0);
        check("flush_no_csr", n_csr - n0, 0);
        n0 = n_ack;
        step(1'b1, mk(32'h3004, 1'b1, 3'b000, 32'h88, 4'd0, 32'd0, 32'd0, 3'b000), 6'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        check("post_flush_ack", n_ack - n0, 1);

        // Asynchronous reset with a request outstanding
        step(1'b1, mk(32'h4000, 1'b1, 3'b000, 32'h99, 4'd0, 32'd0, 32'd0, 3'b000), 6'd0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_req", dm_req, 1'b1);
        es_to_ms_valid = 1'b0;
        dm_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", dm_req, 1'b0);
        check("async_rst_allowin", ms_allowin, 1'b1);
        res_v = 1'b0; res_acked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            ws = ($urandom % 10) < 7;
            em = (($urandom % 10) == 0) ? {1'b1, 5'($urandom)} : 6'($urandom % 32);
            step(($urandom % 4) != 0, rand_bus(), em, ws, ($urandom % 3) == 0,
                 !ws && (($urandom % 30) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and writeback. It registers the 190-bit execute→memory bus and performs stores through a req/ack handshake with byte strobes. It also issues CSR writes, selects the writeback value and forwards it to decode. Memory exceptions are merged into the exception code passed to writeback.

## Interface
- No parameters; all widths are fixed by the pipeline buses.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- es_mem_bus  in  190  MSB→LSB: alu_result[32], rd[5], rd_wen, mem_we, mem_re, wb_sel[3], pc[32], store_data[32], csr_cmd[4], csr_addr[12], op1[32], load_data[32] (already extended), mem_size[3]
- es_to_ms_valid  in  1  upstream valid
- ms_allowin  out  1  stage accepts a new entry
- ms_to_ws_valid  out  1  downstream valid
- ws_allowin  in  1  downstream accepts
- exception_code_em  in  6  upstream exception code; bit5 = exception present
- exception_flush  in  1  squash the stage; synchronous, highest priority
- dm_req  out  1  store request; held until ack
- dm_ack  in  1  store accepted this cycle; sampled only while dm_req=1
- dm_addr  out  32  {alu_result[31:2], 2'b00}
- dm_wstrb  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- csr_we, csr_waddr[12], csr_wdata[32]  out  CSR write port
- ms_wb_bus  out  70  {wb_value[32], rd[5], rd_wen, pc[32]}
- ms_id_data_bus  out  38  {wb_value, rd_wen & ms_valid, rd}
- exception_code_mw  out  6  merged exception code

## Operation
- Accepting an entry:
  - Capture occurs on es_to_ms_valid && ms_allowin; ms_valid <= es_to_ms_valid whenever ms_allowin.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- wb_value selection by wb_sel: 001 → load_data; 010 → pc+4 (32-bit wrap); any other value → alu_result. CSR reads already arrive in alu_result.
- Access size by mem_size: [0]=0 → word; [1:0]=01 → half; [1:0]=11 → byte.
- Store strobes and data:
  - Word: wstrb 1111, wdata = store_data.
  - Half: wstrb 0011 << {addr[1],0}, wdata = {2{store_data[15:0]}}.
  - Byte: wstrb 0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
- Store exceptions:
  - Misaligned store: half with addr[0]=1, or word with addr[1:0]≠0 → code 6'b100110.
  - Store access fault: addr > 32'h6000_0000 → code 6'b100111.
- Exception merge priority: incoming code with bit5=1, then store misaligned, then store access fault, else 0.
- An entry with a nonzero merged code issues no dm_req and no csr_we.
- Store FSM: IDLE, REQ, DONE.
  - IDLE→REQ when a valid, non-excepting store is resident without same-cycle ack.
  - IDLE→DONE on same-cycle ack when ws_allowin=0.
  - REQ→DONE on ack with ws_allowin=0.
  - Any state→IDLE when the entry leaves (ms_to_ws_valid && ws_allowin).
  - dm_req = ms_valid && mem_we && no exception && state≠DONE.
  - ms_ready_go = !(mem_we && no exception) || dm_ack || state==DONE.
- CSR write:
  - csr_we = ms_to_ws_valid && ws_allowin && no exception && csr_cmd∈{0001,0010,0100}.
  - Data: 0001 → op1; 0010 → alu_result|op1; 0100 → alu_result&~op1.
  - Other csr_cmd codes produce no write.
  - csr_we pulses exactly once per instruction.
- Flush: clears ms_valid and forces FSM to IDLE the same cycle. An outstanding dm_req is withdrawn; the memory must not commit an unacked request after withdrawal.

## Timing
- Reset: every output 0 except ms_allowin=1; FSM=IDLE; bus register 0.
- Non-store entries: zero added latency; the entry may leave the cycle after capture.
- Stores: dm_req rises the cycle after capture and stays high with stable addr/wstrb/wdata until ack. Ack in the first cycle gives the same throughput as a non-store.
- Back-pressure (ws_allowin=0): the register holds, outputs stay stable, and no second dm_req or csr_we is issued (DONE state).
- Flush and capture in the same cycle: flush wins and the incoming entry is dropped.
- Reset mid-request: dm_req drops asynchronously.

## Structure
- Shared package holds:
  - bus width constants EXE_MEM_W=190, MEM_WB_W=70
  - wb_sel codes, csr_cmd codes, mem_size decodes
  - exception codes 6'b100110 / 6'b100111 and the address limit 32'h6000_0000
- One sub-module, mem_store_align: combinational strobe/data/misalign generation from addr[1:0], mem_size and store_data.

## Test plan
- Load word, wb_sel=001, load_data=32'hDEADBEEF, ws_allowin=1 → ms_wb_bus wb_value=DEADBEEF one cycle after capture; dm_req stays 0.
- sb at addr 0x1003, store_data=0x000000A5, ack after 3 cycles → dm_req high 3 cycles, dm_wstrb=1000, dm_wdata=A5A5A5A5, dm_addr=0x1000, ms_allowin low until ack.
- sh at 0x1001 → exception_code_mw=100110, no dm_req, entry passes in 1 cycle; sw at 0x6000_0004 → 100111.
- CSR set, alu_result=0x0F, op1=0xF0, ws_allowin low 2 cycles → csr_wdata=0xFF, csr_we asserts exactly once, in the release cycle.
- Store acked with ws_allowin=0 for 4 cycles → FSM DONE, exactly one ack consumed, no re-request.
- exception_flush during REQ → dm_req drops next edge, ms_valid=0, no csr_we; a store captured next proceeds normally.
